// File: rtl/object_velocity_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : object_velocity_scheduler
// Description : Time-multiplexed velocity/acceleration update engine for
//               N_OBJ object slots, with spawn allocation and kill retirement.
//               Build option VEL_SATURATE_EN: saturate same-direction adds.
// Revision    : 1.0 - initial release
// ============================================================================
module object_velocity_scheduler #(
    parameter int N_OBJ = 8,
    parameter int IDX_W = $clog2(N_OBJ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             move_tick,
    input  logic [9:0]       ax,
    input  logic [8:0]       ay,
    input  logic [1:0]       adx,
    input  logic [1:0]       ady,
    input  logic             spawn_req,
    input  logic [9:0]       spawn_vx,
    input  logic [8:0]       spawn_vy,
    input  logic [1:0]       spawn_vdx,
    input  logic [1:0]       spawn_vdy,
    output logic             spawn_ack,
    output logic [IDX_W-1:0] spawn_slot,
    output logic             spawn_full,
    input  logic             kill_req,
    input  logic [IDX_W-1:0] kill_slot,
    input  logic [IDX_W-1:0] rd_slot,
    output logic [9:0]       rd_vx,
    output logic [8:0]       rd_vy,
    output logic [1:0]       rd_vdx,
    output logic [1:0]       rd_vdy,
    output logic [N_OBJ-1:0] active,
    output logic             busy,
    output logic             sweep_done,
    output logic             tick_overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_OBJ - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [9:0]       r_vx  [N_OBJ];
    logic [8:0]       r_vy  [N_OBJ];
    logic [1:0]       r_vdx [N_OBJ];
    logic [1:0]       r_vdy [N_OBJ];
    logic [N_OBJ-1:0] r_active;
    logic [IDX_W-1:0] r_spawn_slot;
    logic             r_tick_pending;
    logic             r_tick_overrun;

    logic             w_tick_any;
    logic             w_grant;
    logic [IDX_W-1:0] w_free_idx;
    logic [N_OBJ-1:0] w_active_nx;

    logic [9:0]       w_cur_vx;
    logic [8:0]       w_cur_vy;
    logic [1:0]       w_cur_vdx;
    logic [1:0]       w_cur_vdy;
    logic [9:0]       w_add_vx;
    logic [8:0]       w_add_vy;
    logic [9:0]       w_nx_vx;
    logic [8:0]       w_nx_vy;
    logic [1:0]       w_nx_vdx;
    logic [1:0]       w_nx_vdy;

    // ------------------------------------------------------------------
    // Slot allocation: lowest-index free slot from the pre-kill mask
    // ------------------------------------------------------------------
    always_comb begin
        w_free_idx = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign spawn_full = &r_active;
    assign w_tick_any = move_tick | r_tick_pending;
    assign w_grant    = (r_state == S_IDLE) && !w_tick_any && spawn_req && !spawn_full;

    // Kill clears first so a grant into the same index still wins.
    always_comb begin
        w_active_nx = r_active;
        if (kill_req) begin
            w_active_nx[kill_slot] = 1'b0;
        end
        if (w_grant) begin
            w_active_nx[w_free_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Shared velocity update datapath for the slot under the sweep index
    // ------------------------------------------------------------------
    assign w_cur_vx  = r_vx[r_idx];
    assign w_cur_vy  = r_vy[r_idx];
    assign w_cur_vdx = r_vdx[r_idx];
    assign w_cur_vdy = r_vdy[r_idx];

`ifdef VEL_SATURATE_EN
    localparam logic [9:0] c_VX_MAX = 10'd1023;
    localparam logic [8:0] c_VY_MAX = 9'd511;
    logic [10:0] w_sum_x;
    logic [9:0]  w_sum_y;
    assign w_sum_x  = {1'b0, w_cur_vx} + {1'b0, ax};
    assign w_sum_y  = {1'b0, w_cur_vy} + {1'b0, ay};
    assign w_add_vx = w_sum_x[10] ? c_VX_MAX : w_sum_x[9:0];
    assign w_add_vy = w_sum_y[9]  ? c_VY_MAX : w_sum_y[8:0];
`else
    assign w_add_vx = w_cur_vx + ax;
    assign w_add_vy = w_cur_vy + ay;
`endif

    always_comb begin
        w_nx_vx  = w_cur_vx;
        w_nx_vdx = w_cur_vdx;
        if (adx[1]) begin
            w_nx_vdx[1] = 1'b1;
            if (w_cur_vdx[0] == adx[0]) begin
                w_nx_vx = w_add_vx;
            end else if (w_cur_vx > ax) begin
                w_nx_vx = w_cur_vx - ax;
            end else begin
                // Opposing accel would cross zero: reverse direction instead.
                w_nx_vdx[0] = ~w_cur_vdx[0];
            end
        end
    end

    always_comb begin
        w_nx_vy  = w_cur_vy;
        w_nx_vdy = w_cur_vdy;
        if (ady[1]) begin
            w_nx_vdy[1] = 1'b1;
            if (w_cur_vdy[0] == ady[0]) begin
                w_nx_vy = w_add_vy;
            end else if (w_cur_vy > ay) begin
                w_nx_vy = w_cur_vy - ay;
            end else begin
                w_nx_vdy[0] = ~w_cur_vdy[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_active       <= '0;
            r_spawn_slot   <= '0;
            r_tick_pending <= 1'b0;
            r_tick_overrun <= 1'b0;
            for (int i = 0; i < N_OBJ; i++) begin
                r_vx[i]  <= '0;
                r_vy[i]  <= '0;
                r_vdx[i] <= '0;
                r_vdy[i] <= '0;
            end
        end else begin
            r_active <= w_active_nx;

            case (r_state)
                S_IDLE: begin
                    if (w_tick_any) begin
                        r_state <= S_SWEEP;
                        r_idx   <= '0;
                    end else if (w_grant) begin
                        r_vx[w_free_idx]  <= spawn_vx;
                        r_vy[w_free_idx]  <= spawn_vy;
                        r_vdx[w_free_idx] <= spawn_vdx;
                        r_vdy[w_free_idx] <= spawn_vdy;
                        r_spawn_slot      <= w_free_idx;
                        r_state           <= S_ACK;
                    end
                end
                S_SWEEP: begin
                    // Inactive slots still consume their cycle to keep sweep length fixed.
                    if (r_active[r_idx]) begin
                        r_vx[r_idx]  <= w_nx_vx;
                        r_vy[r_idx]  <= w_nx_vy;
                        r_vdx[r_idx] <= w_nx_vdx;
                        r_vdy[r_idx] <= w_nx_vdy;
                    end
                    r_idx <= r_idx + c_IDX_ONE;
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // One tick may queue behind a busy engine; a second queued tick is lost.
            if (r_state == S_IDLE) begin
                r_tick_pending <= 1'b0;
            end else if (move_tick) begin
                if (r_tick_pending) begin
                    r_tick_overrun <= 1'b1;
                end else begin
                    r_tick_pending <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign spawn_ack    = (r_state == S_ACK);
    assign spawn_slot   = r_spawn_slot;
    assign sweep_done   = (r_state == S_SWEEP) && (r_idx == c_LAST_IDX);
    assign busy         = (r_state != S_IDLE);
    assign active       = r_active;
    assign tick_overrun = r_tick_overrun;

    assign rd_vx  = r_vx[rd_slot];
    assign rd_vy  = r_vy[rd_slot];
    assign rd_vdx = r_vdx[rd_slot];
    assign rd_vdy = r_vdy[rd_slot];

endmodule
`default_nettype wire

// File: tb/tb_object_velocity_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_object_velocity_scheduler
// Description : Scoreboard bench for object_velocity_scheduler: expected acks
//               and post-sweep velocities are queued, a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_object_velocity_scheduler;

    localparam int N_OBJ = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             move_tick;
    logic [9:0]       ax;
    logic [8:0]       ay;
    logic [1:0]       adx;
    logic [1:0]       ady;
    logic             spawn_req;
    logic [9:0]       spawn_vx;
    logic [8:0]       spawn_vy;
    logic [1:0]       spawn_vdx;
    logic [1:0]       spawn_vdy;
    logic             spawn_ack;
    logic [IDX_W-1:0] spawn_slot;
    logic             spawn_full;
    logic             kill_req;
    logic [IDX_W-1:0] kill_slot;
    logic [IDX_W-1:0] rd_slot;
    logic [9:0]       rd_vx;
    logic [8:0]       rd_vy;
    logic [1:0]       rd_vdx;
    logic [1:0]       rd_vdy;
    logic [N_OBJ-1:0] active;
    logic             busy;
    logic             sweep_done;
    logic             tick_overrun;

    object_velocity_scheduler #(.N_OBJ(N_OBJ), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .move_tick(move_tick),
        .ax(ax), .ay(ay), .adx(adx), .ady(ady),
        .spawn_req(spawn_req), .spawn_vx(spawn_vx), .spawn_vy(spawn_vy),
        .spawn_vdx(spawn_vdx), .spawn_vdy(spawn_vdy),
        .spawn_ack(spawn_ack), .spawn_slot(spawn_slot), .spawn_full(spawn_full),
        .kill_req(kill_req), .kill_slot(kill_slot),
        .rd_slot(rd_slot), .rd_vx(rd_vx), .rd_vy(rd_vy), .rd_vdx(rd_vdx), .rd_vdy(rd_vdy),
        .active(active), .busy(busy), .sweep_done(sweep_done), .tick_overrun(tick_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] vx;
        logic [8:0] vy;
        logic [1:0] vdx;
        logic [1:0] vdy;
    } vel_t;

    int   n_vec = 0;
    int   n_mis = 0;
    int   ack_q[$];
    vel_t sw_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: acks and completed sweeps are matched against queued expectations.
    bit prev_ack = 1'b0;
    bit cmp_pending = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ack    = 1'b0;
            cmp_pending = 1'b0;
        end else begin
            if (spawn_ack) begin
                chk("ack_single_cycle", int'(prev_ack), 0);
                if (ack_q.size() == 0) begin
                    n_vec++; n_mis++;
                    $display("FAIL unexpected_ack: got slot %0d expected no ack", spawn_slot);
                end else begin
                    chk("spawn_slot", int'(spawn_slot), ack_q.pop_front());
                end
            end
            prev_ack = spawn_ack;
            if (cmp_pending) begin
                if (sw_q.size() == 0) begin
                    n_vec++; n_mis++;
                    $display("FAIL unexpected_sweep: got sweep_done expected none");
                end else begin
                    vel_t e;
                    e = sw_q.pop_front();
                    chk("sweep_vx",  int'(rd_vx),  int'(e.vx));
                    chk("sweep_vy",  int'(rd_vy),  int'(e.vy));
                    chk("sweep_vdx", int'(rd_vdx), int'(e.vdx));
                    chk("sweep_vdy", int'(rd_vdy), int'(e.vdy));
                end
            end
            cmp_pending = sweep_done;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        move_tick = 1'b0; spawn_req = 1'b0; kill_req = 1'b0; kill_slot = '0;
        ax = '0; ay = '0; adx = '0; ady = '0; rd_slot = '0;
        spawn_vx = '0; spawn_vy = '0; spawn_vdx = '0; spawn_vdy = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_ack();
        bit got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (spawn_ack) begin
                got = 1'b1;
                break;
            end
        end
        spawn_req = 1'b0;
        if (!got) begin
            n_vec++; n_mis++;
            $display("FAIL ack_timeout: got no ack expected ack within 20 cycles");
        end
        step();
    endtask

    task automatic spawn(input int vx, input int vy, input int vdx, input int vdy, input int exp_slot);
        spawn_vx  = vx[9:0];
        spawn_vy  = vy[8:0];
        spawn_vdx = vdx[1:0];
        spawn_vdy = vdy[1:0];
        ack_q.push_back(exp_slot);
        spawn_req = 1'b1;
        wait_ack();
    endtask

    task automatic push_sw(input int vx, input int vy, input int vdx, input int vdy);
        vel_t e;
        e.vx = vx[9:0]; e.vy = vy[8:0]; e.vdx = vdx[1:0]; e.vdy = vdy[1:0];
        sw_q.push_back(e);
    endtask

    // Single tick; waits for the sweep to end plus one cycle for the monitor.
    task automatic tick();
        bit done = 1'b0;
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) begin
            n_vec++; n_mis++;
            $display("FAIL sweep_timeout: got busy expected idle within 40 cycles");
        end
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Reset state
        chk("rst_active",   int'(active), 0);
        chk("rst_busy",     int'(busy), 0);
        chk("rst_full",     int'(spawn_full), 0);
        chk("rst_ack",      int'(spawn_ack), 0);
        chk("rst_slot",     int'(spawn_slot), 0);
        chk("rst_done",     int'(sweep_done), 0);
        chk("rst_overrun",  int'(tick_overrun), 0);
        chk("rst_rd_vx",    int'(rd_vx), 0);
        chk("rst_rd_vy",    int'(rd_vy), 0);

        // Spawn and accelerate same direction
        spawn(100, 0, 3, 0, 0);
        chk("active_after_spawn", int'(active), 1);
        ax = 10'd5; adx = 2'b11; ay = 9'd0; ady = 2'b00; rd_slot = 3'd0;
        push_sw(105, 0, 3, 0);
        tick();

        // Decelerate, flip, accelerate on Y
        spawn(0, 10, 0, 2, 1);
        adx = 2'b00; ay = 9'd4; ady = 2'b11; rd_slot = 3'd1;
        push_sw(0, 6, 0, 2); tick();
        push_sw(0, 2, 0, 2); tick();
        push_sw(0, 2, 0, 3); tick();
        push_sw(0, 6, 0, 3); tick();
        rd_slot = 3'd0;
        #1;
        chk("slot0_vx_held",  int'(rd_vx), 105);
        chk("slot0_vdx_held", int'(rd_vdx), 3);

        // Fill all slots, then free one while a request is waiting
        for (int i = 2; i < N_OBJ; i++) begin
            spawn(i * 10, i, 0, 0, i);
        end
        chk("full_mask", int'(active), 255);
        chk("full_flag", int'(spawn_full), 1);
        spawn_vx = 10'd77; spawn_vy = 9'd7; spawn_vdx = 2'b10; spawn_vdy = 2'b00;
        spawn_req = 1'b1;
        repeat (4) step();
        chk("no_ack_when_full", int'(spawn_ack), 0);
        chk("idle_when_full",   int'(busy), 0);
        ack_q.push_back(3);
        kill_req = 1'b1; kill_slot = 3'd3;
        step();
        kill_req = 1'b0;
        chk("full_cleared_after_kill", int'(spawn_full), 0);
        wait_ack();
        rd_slot = 3'd3;
        #1;
        chk("respawn_vx", int'(rd_vx), 77);

        // Tick during sweep is queued; a third tick while queued overruns
        do_reset();
        spawn(10, 0, 3, 0, 0);
        ax = 10'd1; adx = 2'b11; ady = 2'b00; rd_slot = 3'd0;
        push_sw(11, 0, 3, 0);
        push_sw(12, 0, 3, 0);
        move_tick = 1'b1; step(); move_tick = 1'b0;
        step(); step();
        move_tick = 1'b1; step(); move_tick = 1'b0;
        repeat (5) step();
        chk("idle_gap_between_sweeps", int'(busy), 0);
        step();
        chk("queued_sweep_started", int'(busy), 1);
        repeat (9) step();
        chk("no_overrun_single_queue", int'(tick_overrun), 0);

        push_sw(13, 0, 3, 0);
        push_sw(14, 0, 3, 0);
        move_tick = 1'b1; step(); move_tick = 1'b0;
        step(); step();
        move_tick = 1'b1; step(); move_tick = 1'b0;
        step();
        move_tick = 1'b1; step(); move_tick = 1'b0;
        chk("overrun_set", int'(tick_overrun), 1);
        repeat (16) step();
        chk("overrun_sticky", int'(tick_overrun), 1);
        chk("idle_after_overrun", int'(busy), 0);

        // Wrap / saturate on same-direction add
        do_reset();
        spawn(1020, 500, 3, 3, 0);
        ax = 10'd10; adx = 2'b11; ay = 9'd20; ady = 2'b11; rd_slot = 3'd0;
`ifdef VEL_SATURATE_EN
        push_sw(1023, 511, 3, 3);
`else
        push_sw(6, 8, 3, 3);
`endif
        tick();

        // Reset in the middle of a sweep
        spawn(50, 0, 0, 0, 1);
        move_tick = 1'b1; step(); move_tick = 1'b0;
        repeat (4) step();
        chk("busy_mid_sweep", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_active", int'(active), 0);
        chk("midrst_busy",   int'(busy), 0);
        rd_slot = 3'd0;
        #1;
        chk("midrst_vx0", int'(rd_vx), 0);
        chk("midrst_vy0", int'(rd_vy), 0);
        rd_slot = 3'd1;
        #1;
        chk("midrst_vx1", int'(rd_vx), 0);

        // Sweep over all-inactive slots changes nothing
        ax = 10'd7; adx = 2'b11; ay = 9'd3; ady = 2'b11; rd_slot = 3'd0;
        push_sw(0, 0, 0, 0);
        tick();

        chk("ack_queue_drained",   ack_q.size(), 0);
        chk("sweep_queue_drained", sw_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/object_velocity_scheduler.md
Name: object_velocity_scheduler

Overview:
- Time-multiplexes a single velocity/acceleration update datapath across N_OBJ fruit/bomb object slots held in an internal register file.
- Allocates free slots to spawn requests and retires slots on kill.
- On each game move tick, sweeps all active slots one per cycle, applying the shared acceleration (gravity/drift).
- Sits between the spawn logic and the per-object position integrators, which read velocities through a combinational read port.

Parameters:
- N_OBJ, 8, number of object slots (power of two, 2..16).
- IDX_W, 3, slot index width, = log2(N_OBJ).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- move_tick  in  1  one-cycle pulse; starts a velocity sweep
- ax  in  10  horizontal acceleration magnitude
- ay  in  9  vertical acceleration magnitude
- adx  in  2  horizontal accel control; [1]=enable, [0]=direction (1 inc, 0 dec)
- ady  in  2  vertical accel control, same encoding
- spawn_req  in  1  level request to launch a new object
- spawn_vx  in  10  initial vx magnitude
- spawn_vy  in  9  initial vy magnitude
- spawn_vdx  in  2  initial vdx
- spawn_vdy  in  2  initial vdy
- spawn_ack  out  1  one-cycle grant pulse
- spawn_slot  out  IDX_W  slot granted, valid with spawn_ack
- spawn_full  out  1  no free slot (combinational from active mask)
- kill_req  in  1  retire slot kill_slot this cycle
- kill_slot  in  IDX_W  slot to retire
- rd_slot  in  IDX_W  read address
- rd_vx  out  10  combinational vx of rd_slot
- rd_vy  out  9  combinational vy of rd_slot
- rd_vdx  out  2  combinational vdx of rd_slot
- rd_vdy  out  2  combinational vdy of rd_slot
- active  out  N_OBJ  per-slot occupied mask
- busy  out  1  state != IDLE
- sweep_done  out  1  pulse on the last sweep cycle
- tick_overrun  out  1  sticky: tick lost

Behaviour:
- Reset: state IDLE; all slot vx/vy/vdx/vdy = 0; active = 0; spawn_ack = 0; spawn_slot = 0; sweep_done = 0; tick_pending = 0; tick_overrun = 0. Reset mid-sweep or mid-ack aborts immediately.
- States: IDLE, SWEEP, ACK.
- IDLE, priority order:
  1. (move_tick | tick_pending) -> SWEEP, idx = 0, tick_pending cleared.
  2. Otherwise, spawn_req & !spawn_full -> write spawn_* into the lowest-index free slot, set its active bit, latch spawn_slot -> ACK.
- ACK: spawn_ack = 1 for exactly this cycle -> IDLE. The requester must drop spawn_req during ACK; if still high in IDLE, it is treated as a new request.
- SWEEP: one slot per cycle, idx 0..N_OBJ-1, written at the cycle's clock edge.
  - Inactive slots are skipped (unchanged) but still take a cycle; sweep length is always N_OBJ cycles.
  - sweep_done = 1 in the idx == N_OBJ-1 cycle, then -> IDLE.
  - Latency: tick at cycle t (IDLE) -> slot i updated at end of cycle t+1+i.
- Per-slot update, X axis (Y identical with vy/ay/vdy/ady):
  - adx[1] = 0: hold vx, vdx.
  - adx[1] = 1: vdx[1] <= 1.
    - vdx[0] == adx[0]: vx <= vx + ax, modulo 2^10.
    - Else if vx > ax: vx <= vx - ax.
    - Else (vx <= ax): vdx[0] <= ~vdx[0], vx unchanged.
- ax/ay/adx/ady are sampled every SWEEP cycle; they must be held stable for the whole sweep.
- move_tick while not IDLE: sets tick_pending. If tick_pending is already 1, sets tick_overrun (cleared only by rst).
- kill_req: clears active[kill_slot] at the edge, in any state, and does not stall the FSM. Kill of the slot currently being swept: active cleared; its velocity write is still allowed (don't-care).
- Same-cycle kill and spawn: spawn chooses from the pre-kill mask, so there is no conflict. A freed slot becomes available the next cycle.
- spawn_full with spawn_req: request stays pending, no ack, no error.
- Read port is purely combinational from the register file; an inactive slot returns its stale contents.

Optional Feature:
- Macro VEL_SATURATE_EN.
- Defined: same-direction addition saturates at 1023 (vx) / 511 (vy) instead of wrapping.
- Undefined: addition wraps modulo 2^10 / 2^9.

Test Plan:
- Spawn, accelerate: rst; spawn vx=100, vdx=2'b11; adx=2'b11, ax=5; tick -> after sweep, rd_vx=105, vdx=2'b11, spawn_slot=0, ack exactly 1 cycle.
- Decelerate then flip: spawn vy=10, vdy=2'b10; ady=2'b11, ay=4.
  - Tick 1 -> vy=6; tick 2 -> vy=2.
  - Tick 3 -> vy=2, vdy=2'b11.
  - Tick 4 -> vy=6.
- Full and kill:
  - Spawn 8 times -> slots 0..7, spawn_full=1; 9th request gets no ack.
  - kill_slot=3 -> next cycle the pending request is acked with spawn_slot=3.
- Tick during sweep: tick at t, 2nd tick at t+3 -> second sweep starts right after sweep_done, tick_overrun=0. A 3rd tick while pending -> tick_overrun=1.
- Wrap/saturate: vx=1020, ax=10, same direction -> vx=6 (wrap); with VEL_SATURATE_EN -> 1023.
- Reset mid-sweep: rst at idx=4 -> active=0, busy=0, all velocities 0 next cycle; a sweep over inactive slots leaves all velocities 0.
